// File: rtl/z3_master_cycle_pkg.sv
// Shared Zorro III master definitions: FSM states, 68030 SIZ codes and byte-lane helpers.
package z3_master_cycle_pkg;

    typedef enum logic [2:0] {
        Z3M_IDLE,
        Z3M_ADDR,
        Z3M_STRB,
        Z3M_WAIT,
        Z3M_TERM,
        Z3M_RECOV
    } z3m_state_t;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_3B   = 2'b11;

    // Active lanes in DS order (bit 3 = byte offset 0); the end is clamped so nothing wraps past the longword.
    function automatic logic [3:0] lane_mask(input logic [1:0] offset, input logic [1:0] siz);
        logic [2:0] len;
        logic [2:0] last;
        logic [3:0] mask;
        len  = (siz == SIZ_LONG) ? 3'd4 : {1'b0, siz};
        last = {1'b0, offset} + len;
        if (last > 3'd4) begin
            last = 3'd4;
        end
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            mask[3 - i] = (3'(i) >= {1'b0, offset}) && (3'(i) < last);
        end
        return mask;
    endfunction

    function automatic logic [31:0] lane_bytes(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/z3_master_cycle_sync_ff.sv
// Multi-stage synchronizer for an asynchronous bus input, reset to its inactive level.
module sync_ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sr <= {STAGES{RST_VAL}};
        end else begin
            sr[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                sr[i] <= sr[i - 1];
            end
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle initiator: runs one address/strobe/data cycle per accepted local request.
module z3_master_cycle
    import z3_master_cycle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BMASTER,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_read,
    input  logic [1:0]  req_siz,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Z_A_o,
    output logic        Z_A_oe,
    output logic        Z_FCS_n_o,
    output logic [3:0]  Z_DS_n_o,
    output logic        Z_READ_o,
    output logic        Z_DOE_o,
    input  logic [31:0] Z_D_i,
    output logic [31:0] Z_D_o,
    output logic        Z_D_oe,
    input  logic        DTACK_n,
    input  logic        BERR_n,
    output logic        busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    z3m_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             lat_read;
    logic [3:0]       lat_mask;
    logic [31:0]      lat_wdata;
    logic             dtack_s;
    logic             berr_s;
    logic             wait_exit;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dtack (
        .CLK(CLK), .RESET(RESET), .d(DTACK_n), .q(dtack_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_berr (
        .CLK(CLK), .RESET(RESET), .d(BERR_n), .q(berr_s)
    );

    // Ready must fall in the same cycle the grant is lost, so it cannot be registered.
    assign req_ready = (state == Z3M_IDLE) && BMASTER && !RESET;
    assign wait_exit = !berr_s || !dtack_s || (cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= Z3M_IDLE;
            cnt       <= '0;
            lat_read  <= 1'b1;
            lat_mask  <= 4'b0000;
            lat_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            Z_A_o     <= 32'h0;
            Z_A_oe    <= 1'b0;
            Z_FCS_n_o <= 1'b1;
            Z_DS_n_o  <= 4'b1111;
            Z_READ_o  <= 1'b1;
            Z_DOE_o   <= 1'b0;
            Z_D_o     <= 32'h0;
            Z_D_oe    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                Z3M_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= Z3M_ADDR;
                        busy      <= 1'b1;
                        lat_read  <= req_read;
                        lat_mask  <= lane_mask(req_addr[1:0], req_siz);
                        lat_wdata <= req_wdata;
                        Z_A_o     <= req_addr;
                        Z_A_oe    <= 1'b1;
                        Z_READ_o  <= req_read;
                    end
                end
                Z3M_ADDR: begin
                    state     <= Z3M_STRB;
                    Z_FCS_n_o <= 1'b0;
                    if (!lat_read) begin
                        Z_D_oe <= 1'b1;
                        Z_D_o  <= lat_wdata;
                    end
                end
                Z3M_STRB: begin
                    state    <= Z3M_WAIT;
                    cnt      <= '0;
                    Z_DOE_o  <= 1'b1;
                    Z_DS_n_o <= ~lat_mask;
                end
                Z3M_WAIT: begin
                    if (wait_exit) begin
                        // Only a clean DTACK (no BERR) counts as success; data is kept for read lanes only.
                        state     <= Z3M_TERM;
                        Z_FCS_n_o <= 1'b1;
                        Z_DS_n_o  <= 4'b1111;
                        Z_DOE_o   <= 1'b0;
                        Z_D_oe    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !(berr_s && !dtack_s);
                        rsp_rdata <= (berr_s && !dtack_s && lat_read) ?
                                     (Z_D_i & lane_bytes(lat_mask)) : 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                Z3M_TERM: begin
                    state     <= Z3M_RECOV;
                    Z_A_oe    <= 1'b0;
                    Z_READ_o  <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                Z3M_RECOV: begin
                    if (dtack_s && berr_s) begin
                        state <= Z3M_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= Z3M_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/z3_master_cycle.md
# z3_master_cycle

Zorro III bus-master cycle initiator for the A4092 local DMA path. It is the initiator counterpart to the card's Zorro III slave decode. It accepts one local transfer request at a time: a 32-bit address, a direction and 68030-style sizing. It then runs a single Zorro III cycle on the bus (address phase, FCS, data strobes with DOE, wait for DTACK or BERR) and returns read data or an error status. It sits between the SCSI-side DMA request logic and the Zorro pad drivers, and is active only while the arbiter reports bus ownership.

## Interface
- `TIMEOUT_CYCLES`, default 255: CLK cycles waited in the data phase before the cycle is aborted with an error.
- `SYNC_STAGES`, default 2: synchronizer depth applied to DTACK_n and BERR_n.
- `CLK` in 1: 25 MHz card clock. All logic is on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `BMASTER` in 1: bus granted to the card, from the arbiter.
- `req_valid` in 1: a transfer request is present.
- `req_ready` out 1: the request is accepted on a cycle where both `req_valid` and `req_ready` are high.
- `req_addr` in 32: byte address; bits [1:0] give the starting lane.
- `req_read` in 1: 1 = read, 0 = write.
- `req_siz` in 2: 68030 SIZ; 01 = byte, 10 = word, 11 = three bytes, 00 = long.
- `req_wdata` in 32: write data, big-endian lanes.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: read data, valid while `rsp_valid` is high.
- `rsp_err` out 1: qualifies `rsp_valid`; set on BERR or timeout.
- `Z_A_o` out 32: address to the pads.
- `Z_A_oe` out 1: address bus drive enable.
- `Z_FCS_n_o` out 1: FCS strobe, active low.
- `Z_DS_n_o` out 4: data strobes; `[3]` covers D31:24.
- `Z_READ_o` out 1: READ line.
- `Z_DOE_o` out 1: data output enable / data phase.
- `Z_D_i` in 32: data bus input.
- `Z_D_o` out 32: data bus output.
- `Z_D_oe` out 1: data drive enable; asserted for writes only.
- `DTACK_n` in 1: slave termination, asynchronous.
- `BERR_n` in 1: bus error, asynchronous.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, ADDR, STRB, WAIT, TERM, RECOV.
- IDLE:
  - `req_ready = BMASTER`.
  - On accept, latch address, direction, size, write data and the lane mask, then go to ADDR.
- ADDR (1 cycle):
  - `Z_A_oe` = 1, `Z_READ_o` driven, FCS still high.
  - Next state is STRB.
- STRB (1 cycle):
  - `Z_FCS_n_o` = 0.
  - For a write, `Z_D_oe` = 1 and `Z_D_o` = the latched data.
  - Next state is WAIT.
- WAIT:
  - `Z_DOE_o` = 1, and `Z_DS_n_o` = the inverted lane mask.
  - The timeout counter is cleared on entry and increments each cycle.
  - Exit priority: synchronized BERR, then synchronized DTACK, then counter == `TIMEOUT_CYCLES`.
  - Any exit goes to TERM.
  - If BERR and DTACK are seen on the same cycle, the result is an error.
- TERM (1 cycle):
  - FCS, DS and DOE go inactive; `Z_D_oe` = 0.
  - `rsp_valid` = 1. `rsp_err` = 1 on BERR or timeout.
  - `rsp_rdata` holds the data captured on the DTACK exit edge: read lanes only, with unused lanes forced to 0. It is all-zero for writes and errors.
  - Next state is RECOV.
- RECOV (1 cycle):
  - `Z_A_oe` = 0.
  - The FSM waits for the synchronized DTACK and BERR to both read high, then returns to IDLE. This prevents a stale DTACK from terminating the next cycle.
- Lane mask:
  - Length is 4 when `req_siz` = 00, otherwise `req_siz`.
  - Lane i (i = 0..3, byte offset) is active when `addr[1:0] <= i < addr[1:0] + len`. The sum is clamped at 4, so there is no wrap into the next longword.
  - Lane i drives `Z_DS_n_o[3-i]`.
  - The wider 3-bit sum is used for the comparison.
- BMASTER loss:
  - In IDLE, `req_ready` drops the same cycle.
  - Once the FSM has left IDLE, the cycle always runs to RECOV; BMASTER is ignored.
- RESET (synchronous, active-high):
  - State goes to IDLE and the counter to 0.
  - All outputs: `req_ready`, `rsp_valid`, `rsp_err`, `Z_A_oe`, `Z_D_oe`, `Z_DOE_o`, `busy` = 0; `Z_FCS_n_o` = 1; `Z_DS_n_o` = 1111; `Z_READ_o` = 1; data and address outputs = 0.
  - A reset during a cycle releases all strobes on the next edge, and no `rsp_valid` is issued.

## Timing
- Accept to FCS low: 2 CLK.
- Accept to DS low: 3 CLK.
- DTACK_n falling to capture: `SYNC_STAGES` + 1 CLK.
- Minimum cycle, accept to `rsp_valid`: 3 + `SYNC_STAGES` + 1 CLK (6 at defaults).
- Back-to-back accepts are at least 7 CLK apart at defaults.
- The timeout fires `TIMEOUT_CYCLES` + 1 CLK after entering WAIT.
- `rsp_valid` is high for exactly one cycle.

## Structure
- Shared package contents:
  - state encodings `Z3M_IDLE`..`Z3M_RECOV`.
  - SIZ constants `SIZ_LONG`/`SIZ_BYTE`/`SIZ_WORD`/`SIZ_3B`.
  - a lane-mask function reused by `scsi_slave`.
- One sub-module, `sync_ff`: a parameterized-depth input synchronizer, instantiated for DTACK_n and BERR_n.

## Test plan
- Long read at 0x40000000:
  - DS_n = 0000 in WAIT.
  - Slave returns 0xDEADBEEF with DTACK held low.
  - Expect `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, and `rsp_valid` 6 CLK after accept.
- Byte write at 0x40000003, data 0x000000A5:
  - DS_n = 1110, `Z_D_oe` = 1 from STRB through WAIT, `Z_READ_o` = 0.
- Three-byte read at offset 2:
  - Mask clamps to lanes 2..3, so DS_n = 1100.
  - Bus data 0x11223344 yields `rsp_rdata` = 0x00003344.
- Error cases:
  - BERR_n asserted together with DTACK_n gives `rsp_err` = 1 and `rsp_rdata` = 0.
  - No DTACK at all gives `rsp_err` = 1 exactly 256 CLK after entering WAIT.
- Stale DTACK:
  - DTACK_n held low past TERM keeps the FSM in RECOV and `req_ready` = 0 until DTACK_n rises.
- Reset and bus loss:
  - RESET asserted in WAIT gives FCS_n = 1, DS_n = 1111 and no `rsp_valid` on the next edge.
  - BMASTER = 0 in IDLE keeps `req_ready` = 0 and no cycle starts.
